// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - K x K convolution window scheduler feeding an external MAC
module conv_window_scheduler #(
    parameter int  KERNEL_SIZE  = 5,
    parameter int  DATA_WIDTH   = 8,
    parameter int  ADDR_WIDTH   = 16,
    parameter int  DIM_WIDTH    = 8,
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           reuse_kernel,
    input  logic [DIM_WIDTH-1:0]           img_width,
    input  logic [DIM_WIDTH-1:0]           img_height,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic                           k_valid,
    input  logic signed [DATA_WIDTH-1:0]   k_data,
    output logic                           k_ready,
    output logic                           mem_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic signed [DATA_WIDTH-1:0]   mem_rdata,
    output logic signed [DATA_WIDTH-1:0]   mac_feature [KERNEL_SIZE][KERNEL_SIZE],
    output logic signed [DATA_WIDTH-1:0]   mac_kernel  [KERNEL_SIZE][KERNEL_SIZE],
    input  logic signed [RESULT_WIDTH-1:0] mac_result,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [RESULT_WIDTH-1:0] out_data,
    output logic [DIM_WIDTH-1:0]           out_row,
    output logic [DIM_WIDTH-1:0]           out_col,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CNT_W = $clog2(KK + 1);
    localparam int IDX_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    localparam logic [CNT_W-1:0]     KK_C   = CNT_W'(KK);
    localparam logic [IDX_W-1:0]     K_LAST = IDX_W'(KERNEL_SIZE - 1);
    localparam logic [DIM_WIDTH-1:0] K_DIM  = DIM_WIDTH'(KERNEL_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_FETCH,
        S_COMPUTE,
        S_OUTPUT,
        S_FINISH
    } state_e;

    state_e state_q, state_d;

    // Pass configuration captured at start
    logic [DIM_WIDTH-1:0]  w_q, h_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  err_q;

    // Current output position and the in-window element index (shared by kernel load and fetch)
    logic [DIM_WIDTH-1:0] row_q, col_q;
    logic [IDX_W-1:0]     kr_q, kc_q;
    logic [IDX_W-1:0]     kr_next, kc_next;
    logic [CNT_W-1:0]     cnt_q;

    // Read-return tracking: which window element the data arriving this cycle belongs to
    logic             rd_valid_q;
    logic [IDX_W-1:0] rd_r_q, rd_c_q;

    logic signed [DATA_WIDTH-1:0] window_q [KERNEL_SIZE][KERNEL_SIZE];
    logic signed [DATA_WIDTH-1:0] kernel_q [KERNEL_SIZE][KERNEL_SIZE];

    logic                           out_valid_q;
    logic signed [RESULT_WIDTH-1:0] out_data_q;
    logic [DIM_WIDTH-1:0]           out_row_q, out_col_q;

    logic                  dims_bad;
    logic                  fetch_last;
    logic                  k_last;
    logic                  col_last;
    logic                  pos_last;
    logic [ADDR_WIDTH-1:0] row_a;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    assign dims_bad   = (img_width < K_DIM) || (img_height < K_DIM);
    assign fetch_last = (cnt_q == KK_C);
    assign k_last     = (kr_q == K_LAST) && (kc_q == K_LAST);
    assign col_last   = (col_q == (w_q - K_DIM));
    assign pos_last   = col_last && (row_q == (h_q - K_DIM));

    // All address terms are brought to ADDR_WIDTH first so the sum wraps modulo 2^ADDR_WIDTH
    assign row_a      = ADDR_WIDTH'(row_q) + ADDR_WIDTH'(kr_q);
    assign fetch_addr = base_q + row_a * ADDR_WIDTH'(w_q) + ADDR_WIDTH'(col_q) + ADDR_WIDTH'(kc_q);

    assign mac_feature = window_q;
    assign mac_kernel  = kernel_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;

    // Raster-order successor of the (kr, kc) element index, wrapping to (0, 0) after the last one
    always_comb begin
        kc_next = kc_q + 1'b1;
        kr_next = kr_q;
        if (kc_q == K_LAST) begin
            kc_next = '0;
            kr_next = (kr_q == K_LAST) ? '0 : kr_q + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dims_bad) begin
                        state_d = S_FINISH;
                    end else if (!reuse_kernel) begin
                        state_d = S_LOAD_K;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_LOAD_K: begin
                if (k_valid && k_last) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_last) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    state_d = pos_last ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        k_ready  = (state_q == S_LOAD_K);
        mem_en   = (state_q == S_FETCH) && !fetch_last;
        mem_addr = mem_en ? fetch_addr : '0;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_FINISH);
        err      = (state_q == S_FINISH) && err_q;
    end

    // Datapath: configuration capture, kernel load, window fill, result register and position walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q         <= '0;
            h_q         <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_r_q      <= '0;
            rd_c_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    window_q[r][c] <= '0;
                    kernel_q[r][c] <= '0;
                end
            end
        end else begin
            // Memory data is only trusted in the cycle right after a read was issued
            rd_valid_q <= mem_en;
            rd_r_q     <= kr_q;
            rd_c_q     <= kc_q;
            if (rd_valid_q) begin
                window_q[rd_r_q][rd_c_q] <= mem_rdata;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w_q    <= img_width;
                        h_q    <= img_height;
                        base_q <= base_addr;
                        err_q  <= dims_bad;
                        row_q  <= '0;
                        col_q  <= '0;
                        kr_q   <= '0;
                        kc_q   <= '0;
                        cnt_q  <= '0;
                    end
                end
                S_LOAD_K: begin
                    if (k_valid) begin
                        kernel_q[kr_q][kc_q] <= k_data;
                        kr_q <= kr_next;
                        kc_q <= kc_next;
                    end
                end
                S_FETCH: begin
                    if (fetch_last) begin
                        cnt_q <= '0;
                        kr_q  <= '0;
                        kc_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        kr_q  <= kr_next;
                        kc_q  <= kc_next;
                    end
                end
                S_COMPUTE: begin
                    out_data_q  <= mac_result;
                    out_row_q   <= row_q;
                    out_col_q   <= col_q;
                    out_valid_q <= 1'b1;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - self-checking bench for conv_window_scheduler
module tb_conv_window_scheduler;

    localparam int K  = 3;
    localparam int RW = 20;

    typedef struct {
        int          w;
        int          h;
        logic [15:0] base;
        bit          reuse;
        int          kmode;
        int          stall;
        int          exp_n;
        int          exp_reads;
        bit          exp_err;
        int          exp_first;
        bit          chk_wrap;
    } vec_t;

    typedef struct {
        logic signed [RW-1:0] data;
        logic [7:0]           row;
        logic [7:0]           col;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 reuse_kernel = 1'b0;
    logic [7:0]           img_width = '0;
    logic [7:0]           img_height = '0;
    logic [15:0]          base_addr = '0;
    logic                 k_valid = 1'b0;
    logic signed [7:0]    k_data = '0;
    logic                 k_ready;
    logic                 mem_en;
    logic [15:0]          mem_addr;
    logic signed [7:0]    mem_rdata = '0;
    logic signed [7:0]    mac_feature [K][K];
    logic signed [7:0]    mac_kernel  [K][K];
    logic signed [RW-1:0] mac_result;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [RW-1:0] out_data;
    logic [7:0]           out_row, out_col;
    logic                 busy, done, err;

    conv_window_scheduler #(
        .KERNEL_SIZE(K),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .DIM_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .reuse_kernel(reuse_kernel),
        .img_width   (img_width),
        .img_height  (img_height),
        .base_addr   (base_addr),
        .k_valid     (k_valid),
        .k_data      (k_data),
        .k_ready     (k_ready),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mac_feature (mac_feature),
        .mac_kernel  (mac_kernel),
        .mac_result  (mac_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem [0:65535];
    int   kern_model [K*K];
    exp_t sb [$];
    logic [15:0] addr_log [$];

    int n_cmp = 0;
    int n_fail = 0;
    int n_reads = 0, n_results = 0, n_done = 0, n_err = 0, n_kready = 0;
    int first_data = 0;
    bit first_seen = 1'b0;
    int stall_len = 0;
    int wcnt = 0;
    int mac_acc;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference MAC
    always_comb begin
        mac_acc = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                mac_acc += int'(mac_feature[i][j]) * int'(mac_kernel[i][j]);
        mac_result = mac_acc[RW-1:0];
    end

    // Synchronous-read feature memory; junk on the data bus when no read was issued
    always @(posedge clk) begin
        mem_rdata <= mem_en ? mem[mem_addr] : 8'($urandom);
    end

    // Downstream ready: holds ready low for stall_len valid cycles before each accept
    always @(posedge clk) begin
        #1;
        if (!out_valid) begin
            wcnt = 0;
            out_ready = (stall_len == 0);
        end else if (wcnt < stall_len) begin
            out_ready = 1'b0;
            wcnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor and scoreboard pop
    always @(negedge clk) begin
        if (mem_en) begin
            n_reads++;
            addr_log.push_back(mem_addr);
        end
        if (done) n_done++;
        if (err) n_err++;
        if (k_ready) n_kready++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("out_data", out_data, sb[0].data);
                check("out_row", out_row, sb[0].row);
                check("out_col", out_col, sb[0].col);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_data = int'(out_data);
                end
                if (out_ready) begin
                    sb.delete(0);
                    n_results++;
                end
            end
        end
    end

    task automatic set_kernel(input int mode);
        for (int e = 0; e < K*K; e++)
            kern_model[e] = (mode == 0) ? 1 : ((e == 4) ? -1 : 0);
    endtask

    task automatic push_expected(input int w, input int h, input logic [15:0] base);
        for (int r = 0; r <= h - K; r++) begin
            for (int c = 0; c <= w - K; c++) begin
                exp_t        e;
                int          s;
                logic [15:0] a;
                s = 0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        a = base + 16'((r + i) * w + c + j);
                        s += int'(mem[a]) * kern_model[i*K + j];
                    end
                end
                e.data = RW'(s);
                e.row  = 8'(r);
                e.col  = 8'(c);
                sb.push_back(e);
            end
        end
    endtask

    task automatic feed_kernel();
        for (int e = 0; e < K*K; e++) begin
            int wc;
            if (e == 4) begin
                k_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            k_valid = 1'b1;
            k_data  = 8'(kern_model[e]);
            wc = 0;
            while (!k_ready && wc < 100) begin
                @(posedge clk);
                #1;
                wc++;
            end
            check("k_ready_wait", k_ready, 1);
            @(posedge clk);
            #1;
        end
        k_valid = 1'b0;
        check("k_ready_drop", k_ready, 0);
    endtask

    task automatic clear_counts();
        n_reads = 0; n_results = 0; n_done = 0; n_err = 0; n_kready = 0;
        addr_log.delete();
        first_seen = 1'b0;
        first_data = 0;
    endtask

    task automatic issue_start(input vec_t v);
        img_width    = 8'(v.w);
        img_height   = 8'(v.h);
        base_addr    = v.base;
        reuse_kernel = v.reuse;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input vec_t v, input string tag);
        int wc;
        clear_counts();
        stall_len = v.stall;
        if (!v.exp_err) begin
            if (!v.reuse) set_kernel(v.kmode);
            push_expected(v.w, v.h, v.base);
        end
        issue_start(v);
        if (!v.reuse && !v.exp_err) feed_kernel();
        wc = 0;
        while (!done && wc < 5000) begin
            @(posedge clk);
            #1;
            wc++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_err_with_done"}, err, v.exp_err);
        check({tag, "_sb_empty_at_done"}, sb.size(), 0);
        if (v.exp_err) check({tag, "_err_latency"}, (wc <= 1), 1);
        @(posedge clk);
        #1;
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_n_err"}, n_err, v.exp_err);
        check({tag, "_n_results"}, n_results, v.exp_n);
        check({tag, "_n_reads"}, n_reads, v.exp_reads);
        check({tag, "_kready_seen"}, (n_kready > 0), !(v.reuse || v.exp_err));
        if (v.exp_n > 0) check({tag, "_first_data"}, first_data, v.exp_first);
        if (v.chk_wrap && addr_log.size() == 9) begin
            check({tag, "_addr0"}, addr_log[0], 16'hFFFE);
            check({tag, "_addr1"}, addr_log[1], 16'hFFFF);
            check({tag, "_addr2"}, addr_log[2], 16'h0000);
            check({tag, "_addr8"}, addr_log[8], 16'h0006);
        end
        sb.delete();
        stall_len = 0;
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_k_ready"}, k_ready, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_row"}, out_row, 0);
        check({tag, "_out_col"}, out_col, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_window"}, mac_feature[1][1], 0);
        check({tag, "_kernel"}, mac_kernel[2][2], 0);
    endtask

    initial begin
        vec_t vecs [6];
        vec_t zero_vec;
        int   wc;

        vecs[0] = '{4, 4, 16'h0000, 1'b0, 0, 0, 4, 36, 1'b0, 45, 1'b0};
        vecs[1] = '{4, 4, 16'h0000, 1'b0, 0, 5, 4, 36, 1'b0, 45, 1'b0};
        vecs[2] = '{4, 4, 16'd100,  1'b0, 1, 0, 4, 36, 1'b0, 128, 1'b0};
        vecs[3] = '{4, 4, 16'd100,  1'b1, 1, 0, 4, 36, 1'b0, 128, 1'b0};
        vecs[4] = '{2, 5, 16'h0000, 1'b0, 0, 0, 0, 0,  1'b1, 0, 1'b0};
        vecs[5] = '{3, 3, 16'hFFFE, 1'b1, 1, 0, 1, 9,  1'b0, -2, 1'b1};
        zero_vec = '{3, 3, 16'h0000, 1'b1, 0, 0, 1, 9, 1'b0, 0, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            mem[i]       = 8'(i);
            mem[100 + i] = (i % 2 != 0) ? 8'h80 : 8'h7F;
        end
        for (int e = 0; e < K*K; e++) kern_model[e] = 0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_pass(zero_vec, "zero_kernel");

        for (int i = 0; i < 6; i++) run_pass(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of fetching the second window
        clear_counts();
        set_kernel(0);
        push_expected(4, 4, 16'h0000);
        issue_start(vecs[0]);
        feed_kernel();
        wc = 0;
        while (n_reads < 12 && wc < 2000) begin
            @(posedge clk);
            #1;
            wc++;
        end
        check("midreset_reached_fetch", (n_reads >= 12), 1);
        check("midreset_first_result", n_results, 1);
        rst_n = 1'b0;
        #2;
        check_reset_zero("midreset");
        sb.delete();
        for (int e = 0; e < K*K; e++) kern_model[e] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_pass(vecs[0], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences a single-output convolution over a feature map stored in on-chip feature memory, using the team's combinational K×K multiply-accumulate unit.
- Loads a K×K kernel over a valid/ready stream.
- For each output position: fetches the K×K window from memory, presents window and kernel to the MAC, registers the MAC result, and emits it with its (row, col) tag on a valid/ready output stream.
- Sits between the feature SRAM, the MAC instance and the downstream activation/pooling stage.

Parameters:
KERNEL_SIZE, 5, window edge K; must match the connected MAC instance
DATA_WIDTH, 8, signed pixel and weight width
ADDR_WIDTH, 16, feature-memory word address width
DIM_WIDTH, 8, width of the runtime image-dimension inputs
RESULT_WIDTH, 2*DATA_WIDTH+$clog2(KERNEL_SIZE*KERNEL_SIZE), derived; MAC result width (not overridable)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a convolution pass; ignored unless in IDLE
reuse_kernel  in  1  sampled with start; 1 = skip kernel load
img_width  in  DIM_WIDTH  feature-map columns W, sampled at start
img_height  in  DIM_WIDTH  feature-map rows H, sampled at start
base_addr  in  ADDR_WIDTH  address of pixel (0,0), sampled at start
k_valid  in  1  kernel weight valid
k_data  in  DATA_WIDTH  kernel weight, raster order (row 0 col 0 first)
k_ready  out  1  kernel weight accepted when k_valid&&k_ready
mem_en  out  1  feature-memory read enable
mem_addr  out  ADDR_WIDTH  read address
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_en
mac_feature  out  DATA_WIDTH x [K][K]  window registers to MAC feature input
mac_kernel  out  DATA_WIDTH x [K][K]  kernel registers to MAC kernel input
mac_result  in  RESULT_WIDTH  combinational MAC result
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_data  out  RESULT_WIDTH  signed convolution result
out_row  out  DIM_WIDTH  output row index
out_col  out  DIM_WIDTH  output column index
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of pass
err  out  1  one-cycle pulse (same cycle as done) when dimensions are invalid

Behaviour:
- Reset (rst_n=0, asynchronous, any state): FSM→IDLE.
  - All outputs 0: k_ready, mem_en, mem_addr, out_valid, out_data, out_row, out_col, busy, done, err.
  - Window, kernel and position registers cleared.
- States: IDLE, LOAD_K, FETCH, COMPUTE, OUTPUT, FINISH.
- IDLE + start:
  - Latch W, H, base_addr, reuse_kernel.
  - If W<K or H<K: go to FINISH with err.
  - Else if reuse_kernel=0: go to LOAD_K.
  - Else: go to FETCH with row=col=0.
- start in any other state is ignored.
- LOAD_K:
  - k_ready=1.
  - Each handshake writes kernel[e/K][e%K], e=0..K*K-1.
  - After the K*K-th handshake go to FETCH (row=col=0); k_ready drops the next cycle.
  - Stalls indefinitely with k_valid=0.
  - Kernel registers hold between passes.
- FETCH:
  - For e=0..K*K-1 on consecutive cycles: mem_en=1, mem_addr=base_addr+(row+e/K)*W+(col+e%K), truncated to ADDR_WIDTH.
  - mem_rdata arriving one cycle later writes window[e/K][e%K].
  - Occupies K*K+1 cycles; mem_en=0 on the final cycle.
  - The window is fully refetched for every position (no reuse).
- COMPUTE:
  - One cycle.
  - out_data<=mac_result, out_row<=row, out_col<=col, out_valid<=1.
  - Go to OUTPUT.
- OUTPUT:
  - out_valid held; out_data/out_row/out_col stable until out_valid&&out_ready.
  - On the handshake, advance col.
  - If col==W-K: col=0 and row+1.
  - If row==H-K and col==W-K: go to FINISH; else go to FETCH.
  - out_valid deasserts the cycle after the handshake.
- FINISH:
  - One cycle; done=1 (err=1 if the invalid-dim path was taken).
  - Go to IDLE.
  - busy=0 from IDLE onward.
- Outputs: (H-K+1)*(W-K+1) results in raster order.
- Per-result latency from FETCH entry to out_valid: K*K+2 cycles.
- Arithmetic:
  - The block performs no MAC arithmetic; signedness and width follow the MAC.
  - Address arithmetic is unsigned and wraps modulo 2^ADDR_WIDTH.
- Boundaries:
  - W==K and H==K yields exactly one result.
  - reuse_kernel=1 after reset uses the all-zero kernel, so results are 0.
  - mem_rdata is ignored outside the cycle after mem_en.

Test Plan:
1. K=3, reset, start(reuse=0, W=H=4, base=0), kernel all 1, memory[i]=i for i=0..15 → outputs (0,0)=45, (0,1)=54, (1,0)=81, (1,1)=90 in order; done pulse after the 4th handshake; err=0.
2. Same pass with out_ready low for 5 cycles on each result → out_data/row/col stable while stalled; no extra mem_en pulses; same 4 values.
3. K=3, kernel −1 at centre, 0 elsewhere, pixels 127 and −128 mixed, reuse=0 → signed results −127/128 at the correct positions; second start with reuse=1 and no k_valid traffic → identical results.
4. K=3, start with W=2, H=5 → no k_ready, no mem_en; done and err pulse together within 2 cycles; busy returns to 0.
5. K=3, assert rst_n=0 mid-FETCH of the second window → immediate IDLE, all outputs 0; a new start completes a full pass correctly.
6. K=3, base_addr=0xFFFE, W=H=3 → mem_addr sequence wraps (0xFFFE, 0xFFFF, 0x0000, ...); exactly 9 reads, 1 result, done.
